// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encodings and default constants.
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        FS_FETCH = 2'd0,
        FS_HOLD  = 2'd1,
        FS_KILL  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: squash beats load, and load is blocked while ID holds.
module if_id_reg
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        squash,
    input  logic        hold,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        valid
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= 32'h0;
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (squash) begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (load && !hold) begin
            pc    <= load_pc;
            instr <= load_instr;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the imem handshake and feeds the IF/ID register.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc,
    input  logic        redirect,
    input  logic        id_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] if_pc,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic        id_valid
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  buf_q, buf_d;
    logic [31:0]  tgt_q, tgt_d;
    logic         id_acc, redir_ok;
    logic         load, squash;
    logic [31:0]  load_instr;

    assign id_acc    = !id_valid || !id_stall;
    assign redir_ok  = redirect && id_valid && !id_stall;
    assign if_pc     = pc_q;
    assign imem_addr = pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FS_FETCH;
            pc_q    <= RESET_PC;
            buf_q   <= 32'h0;
            tgt_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            tgt_q   <= tgt_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        buf_d      = buf_q;
        tgt_d      = tgt_q;
        load       = 1'b0;
        squash     = 1'b0;
        load_instr = imem_rdata;
        imem_req   = !rst && (state_q != FS_HOLD);

        unique case (state_q)
            FS_FETCH: begin
                if (redir_ok) begin
                    squash = 1'b1;
                    if (imem_ready) begin
                        pc_d = npc;
                    end else begin
                        tgt_d   = npc;
                        state_d = FS_KILL;
                    end
                end else if (imem_ready) begin
                    if (id_acc) begin
                        load = 1'b1;
                        pc_d = npc;
                    end else begin
                        buf_d   = imem_rdata;
                        state_d = FS_HOLD;
                    end
                end
            end
            FS_HOLD: begin
                if (redir_ok) begin
                    squash  = 1'b1;
                    pc_d    = npc;
                    state_d = FS_FETCH;
                end else if (id_acc) begin
                    load       = 1'b1;
                    load_instr = buf_q;
                    pc_d       = npc;
                    state_d    = FS_FETCH;
                end
            end
            FS_KILL: begin
                // The wrong-path word is dropped; only the address change matters.
                if (imem_ready) begin
                    pc_d    = tgt_q;
                    state_d = FS_FETCH;
                end
            end
            default: state_d = FS_FETCH;
        endcase
    end

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .squash    (squash),
        .hold      (!id_acc),
        .load_pc   (pc_q),
        .load_instr(load_instr),
        .pc        (id_pc),
        .instr     (id_instr),
        .valid     (id_valid)
    );

endmodule
